// File: rtl/bp_fe_bht_sched.sv
// bp_fe_bht_sched
// Port scheduler for the front-end branch history table. One single-ported
// 1RW counter SRAM is shared between the fetch prediction read, buffered
// read-modify-write counter updates and the table-initialisation sweep.
// Saturating counter arithmetic for updates is done here.
//
// Optional feature: define BP_FE_BHT_SCHED_FLUSH_EN to let flush_i empty the
// update FIFO and re-run the initialisation sweep. Without it flush_i is
// ignored and the table is only initialised after reset.

module bp_fe_bht_sched #(
   parameter int bht_idx_width_p   = 3,
   parameter int bp_cnt_sat_bits_p = 2,
   parameter int upd_fifo_els_p    = 4
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         flush_i,

   input  logic                         r_v_i,
   input  logic [bht_idx_width_p-1:0]   r_idx_i,
   output logic                         r_ready_o,
   output logic                         predict_v_o,
   output logic                         predict_o,

   input  logic                         w_v_i,
   input  logic [bht_idx_width_p-1:0]   w_idx_i,
   input  logic                         w_taken_i,
   output logic                         w_ready_o,

   output logic                         init_done_o,

   output logic                         mem_v_o,
   output logic                         mem_w_o,
   output logic [bht_idx_width_p-1:0]   mem_addr_o,
   output logic [bp_cnt_sat_bits_p-1:0] mem_data_o,
   input  logic [bp_cnt_sat_bits_p-1:0] mem_data_i
);

   localparam int ptr_w_lp = $clog2(upd_fifo_els_p);

   // Weakly not-taken: MSB clear, all lower bits set
   localparam logic [bp_cnt_sat_bits_p-1:0] cnt_init_lp =
      bp_cnt_sat_bits_p'((1 << (bp_cnt_sat_bits_p - 1)) - 1);
   localparam logic [bp_cnt_sat_bits_p-1:0] cnt_max_lp  = '1;
   localparam logic [bp_cnt_sat_bits_p-1:0] cnt_min_lp  = '0;
   localparam logic [bht_idx_width_p-1:0]   idx_last_lp = '1;

   // Top-level scheduler states
   localparam logic [0:0] state_init_lp  = 1'b0;
   localparam logic [0:0] state_ready_lp = 1'b1;

   // Read-modify-write sub-phases; RD is the cycle a FIFO entry is popped
   // and its counter read, WR is the following cycle that writes it back
   localparam logic [1:0] rmw_idle_lp = 2'd0;
   localparam logic [1:0] rmw_rd_lp   = 2'd1;
   localparam logic [1:0] rmw_wr_lp   = 2'd2;

   logic [0:0]                   state_q;
   logic [bht_idx_width_p-1:0]   init_addr_q;
   logic [1:0]                   rmw_state_q;
   logic [1:0]                   rmw_phase;
   logic [bht_idx_width_p-1:0]   rmw_idx_q;
   logic                         rmw_taken_q;
   logic                         flush_pend_q;
   logic                         predict_v_q;

   logic [bht_idx_width_p:0]     fifo_mem [upd_fifo_els_p];
   logic [ptr_w_lp:0]            wr_ptr_q;
   logic [ptr_w_lp:0]            rd_ptr_q;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [bht_idx_width_p:0]     head_entry;
   logic [bht_idx_width_p-1:0]   head_idx;
   logic                         head_taken;

   logic                         enq;
   logic                         pop;
   logic                         rd_accept;
   logic [bp_cnt_sat_bits_p-1:0] cnt_next;

   logic                         flush_now;
   logic                         flush_defer;
   logic                         init_restart;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[ptr_w_lp] != rd_ptr_q[ptr_w_lp]) &&
                       (wr_ptr_q[ptr_w_lp-1:0] == rd_ptr_q[ptr_w_lp-1:0]);
   assign head_entry = fifo_mem[rd_ptr_q[ptr_w_lp-1:0]];
   assign head_idx   = head_entry[bht_idx_width_p:1];
   assign head_taken = head_entry[0];

   assign enq = w_v_i && w_ready_o;

`ifdef BP_FE_BHT_SCHED_FLUSH_EN
   // A flush seen during RD waits one cycle so the WR of that update lands
   assign flush_now    = (state_q == state_ready_lp) &&
                         (flush_pend_q || (flush_i && (rmw_phase != rmw_rd_lp)));
   assign flush_defer  = (state_q == state_ready_lp) && flush_i && (rmw_phase == rmw_rd_lp);
   assign init_restart = (state_q == state_init_lp) && flush_i;
`else
   logic unused_flush;
   assign unused_flush = flush_i;
   assign flush_now    = 1'b0;
   assign flush_defer  = 1'b0;
   assign init_restart = 1'b0;
`endif

   assign init_done_o = (state_q == state_ready_lp);
   assign predict_v_o = predict_v_q;
   assign predict_o   = predict_v_q & mem_data_i[bp_cnt_sat_bits_p-1];

   // Saturating increment/decrement of the counter returned by the RD phase
   always_comb begin
      cnt_next = mem_data_i;
      if (rmw_taken_q) begin
         if (mem_data_i != cnt_max_lp) begin
            cnt_next = mem_data_i + bp_cnt_sat_bits_p'(1);
         end
      end else begin
         if (mem_data_i != cnt_min_lp) begin
            cnt_next = mem_data_i - bp_cnt_sat_bits_p'(1);
         end
      end
   end

   // Single-port arbitration: sweep in INIT, else WR > full-pop > fetch > pop
   always_comb begin
      mem_v_o    = 1'b0;
      mem_w_o    = 1'b0;
      mem_addr_o = '0;
      mem_data_o = '0;
      r_ready_o  = 1'b0;
      w_ready_o  = 1'b0;
      pop        = 1'b0;
      rd_accept  = 1'b0;
      rmw_phase  = rmw_idle_lp;
      if (reset_n_i) begin
         if (state_q == state_init_lp) begin
            mem_v_o    = 1'b1;
            mem_w_o    = 1'b1;
            mem_addr_o = init_addr_q;
            mem_data_o = cnt_init_lp;
         end else begin
            w_ready_o = !fifo_full;
            if (rmw_state_q == rmw_wr_lp) begin
               rmw_phase  = rmw_wr_lp;
               mem_v_o    = 1'b1;
               mem_w_o    = 1'b1;
               mem_addr_o = rmw_idx_q;
               mem_data_o = cnt_next;
            end else if (fifo_full) begin
               rmw_phase  = rmw_rd_lp;
               pop        = 1'b1;
               mem_v_o    = 1'b1;
               mem_addr_o = head_idx;
            end else begin
               r_ready_o = 1'b1;
               if (r_v_i) begin
                  rd_accept  = 1'b1;
                  mem_v_o    = 1'b1;
                  mem_addr_o = r_idx_i;
               end else if (!fifo_empty) begin
                  rmw_phase  = rmw_rd_lp;
                  pop        = 1'b1;
                  mem_v_o    = 1'b1;
                  mem_addr_o = head_idx;
               end
            end
         end
      end
   end

   // Scheduler state, init sweep address and RMW bookkeeping
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= state_init_lp;
         init_addr_q  <= '0;
         rmw_state_q  <= rmw_idle_lp;
         rmw_idx_q    <= '0;
         rmw_taken_q  <= 1'b0;
         flush_pend_q <= 1'b0;
         predict_v_q  <= 1'b0;
      end else begin
         flush_pend_q <= flush_defer;
         predict_v_q  <= rd_accept;
         if (state_q == state_init_lp) begin
            rmw_state_q <= rmw_idle_lp;
            if (init_restart) begin
               init_addr_q <= '0;
            end else if (init_addr_q == idx_last_lp) begin
               init_addr_q <= '0;
               state_q     <= state_ready_lp;
            end else begin
               init_addr_q <= init_addr_q + 1'b1;
            end
         end else if (flush_now) begin
            state_q     <= state_init_lp;
            init_addr_q <= '0;
            rmw_state_q <= rmw_idle_lp;
         end else if (rmw_phase == rmw_rd_lp) begin
            rmw_state_q <= rmw_wr_lp;
            rmw_idx_q   <= head_idx;
            rmw_taken_q <= head_taken;
         end else begin
            rmw_state_q <= rmw_idle_lp;
         end
      end
   end

   // Update FIFO pointers; a flush discards every queued update
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush_now) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (enq) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Update FIFO storage holds {index, taken}; contents need no reset
   always_ff @(posedge clk_i) begin
      if (enq) begin
         fifo_mem[wr_ptr_q[ptr_w_lp-1:0]] <= {w_idx_i, w_taken_i};
      end
   end

endmodule

// File: tb/tb_bp_fe_bht_sched.sv
// tb_bp_fe_bht_sched
// Directed bench for bp_fe_bht_sched with an 8-entry table, 2-bit counters
// and a 4-deep update FIFO. A behavioural SRAM answers the DUT, and a
// reference model (table array plus update queue) predicts every output on
// every cycle. Honours BP_FE_BHT_SCHED_FLUSH_EN when it is defined.

module tb_bp_fe_bht_sched;

   localparam int IW    = 3;
   localparam int CW    = 2;
   localparam int DEPTH = 4;
   localparam int N     = 8;

`ifdef BP_FE_BHT_SCHED_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          flush_i;
   logic          r_v_i;
   logic [IW-1:0] r_idx_i;
   logic          r_ready_o;
   logic          predict_v_o;
   logic          predict_o;
   logic          w_v_i;
   logic [IW-1:0] w_idx_i;
   logic          w_taken_i;
   logic          w_ready_o;
   logic          init_done_o;
   logic          mem_v_o;
   logic          mem_w_o;
   logic [IW-1:0] mem_addr_o;
   logic [CW-1:0] mem_data_o;
   logic [CW-1:0] mem_data_i;

   int n_checks = 0;
   int n_fails  = 0;

   bp_fe_bht_sched #(
      .bht_idx_width_p  (IW),
      .bp_cnt_sat_bits_p(CW),
      .upd_fifo_els_p   (DEPTH)
   ) dut (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .flush_i    (flush_i),
      .r_v_i      (r_v_i),
      .r_idx_i    (r_idx_i),
      .r_ready_o  (r_ready_o),
      .predict_v_o(predict_v_o),
      .predict_o  (predict_o),
      .w_v_i      (w_v_i),
      .w_idx_i    (w_idx_i),
      .w_taken_i  (w_taken_i),
      .w_ready_o  (w_ready_o),
      .init_done_o(init_done_o),
      .mem_v_o    (mem_v_o),
      .mem_w_o    (mem_w_o),
      .mem_addr_o (mem_addr_o),
      .mem_data_o (mem_data_o),
      .mem_data_i (mem_data_i)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural 1RW SRAM: read data appears the cycle after the read
   logic [CW-1:0] sram [N];
   logic [CW-1:0] sram_rdata;
   assign mem_data_i = sram_rdata;

   always @(posedge clk_i) begin
      if (mem_v_o) begin
         if (mem_w_o) sram[mem_addr_o] <= mem_data_o;
         else         sram_rdata       <= sram[mem_addr_o];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit rv, input int ridx, input bit wv, input int widx,
                                input bit wt, input bit fl);
      @(negedge clk_i);
      r_v_i     = rv;
      r_idx_i   = IW'(ridx);
      w_v_i     = wv;
      w_idx_i   = IW'(widx);
      w_taken_i = wt;
      flush_i   = fl;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   // Reference model
   typedef struct packed {
      logic [IW-1:0] idx;
      logic          taken;
   } upd_t;

   logic [CW-1:0] ref_tbl [N];
   upd_t          upd_q [$];
   bit            m_ready;
   int            m_sweep;
   bit            m_wr_pend;
   upd_t          m_wr;
   bit            m_flush_pend;
   bit            m_pred_pend;
   bit            m_pred_bit;

   function automatic logic [CW-1:0] satUpdate(input logic [CW-1:0] c, input logic taken);
      if (taken) return (c == 2'b11) ? c : c + 2'd1;
      else       return (c == 2'b00) ? c : c - 2'd1;
   endfunction

   // Compare process: mid-cycle, predict all outputs, compare, then advance
   always @(negedge clk_i) begin
      int  e_v, e_w, e_addr, e_data, e_rr, e_wr, e_done, e_pv, e_p;
      bit  nx_pred, full, popped, go_init;
      #2;
      e_v = 0; e_w = 0; e_addr = 0; e_data = 0; e_rr = 0; e_wr = 0;
      e_done = 0; e_pv = 0; e_p = 0;
      nx_pred = 0; popped = 0; go_init = 0;
      if (!reset_n_i) begin
         m_ready = 0; m_sweep = 0; m_wr_pend = 0; m_flush_pend = 0; m_pred_pend = 0;
         upd_q.delete();
      end else begin
         e_done = int'(m_ready);
         e_pv   = int'(m_pred_pend);
         e_p    = m_pred_pend ? int'(m_pred_bit) : 0;
         if (!m_ready) begin
            e_v = 1; e_w = 1; e_addr = m_sweep; e_data = 1;
            ref_tbl[m_sweep] = 2'b01;
            if (FLUSH_EN && flush_i) m_sweep = 0;
            else if (m_sweep == N - 1) begin
               m_sweep = 0;
               m_ready = 1;
            end else m_sweep++;
         end else begin
            full = (upd_q.size() == DEPTH);
            e_wr = int'(!full);
            e_rr = int'(!m_wr_pend && !full);
            if (m_wr_pend) begin
               e_v = 1; e_w = 1; e_addr = int'(m_wr.idx);
               e_data = int'(satUpdate(ref_tbl[m_wr.idx], m_wr.taken));
               ref_tbl[m_wr.idx] = satUpdate(ref_tbl[m_wr.idx], m_wr.taken);
               m_wr_pend = 0;
            end else if (full || (!r_v_i && upd_q.size() > 0)) begin
               m_wr = upd_q.pop_front();
               e_v = 1; e_addr = int'(m_wr.idx);
               m_wr_pend = 1;
               popped = 1;
            end else if (r_v_i) begin
               e_v = 1; e_addr = int'(r_idx_i);
               nx_pred = 1;
               m_pred_bit = ref_tbl[r_idx_i][CW-1];
            end
            if (w_v_i && !full) upd_q.push_back('{idx: w_idx_i, taken: w_taken_i});
            if (FLUSH_EN) begin
               go_init = m_flush_pend || (flush_i && !popped);
               m_flush_pend = flush_i && popped;
               if (go_init) begin
                  m_ready = 0; m_sweep = 0; m_wr_pend = 0;
                  upd_q.delete();
               end
            end
         end
         m_pred_pend = nx_pred;
      end
      checkOutput("mem_v",     32'(mem_v_o),     e_v);
      checkOutput("mem_w",     32'(mem_w_o),     e_w);
      checkOutput("mem_addr",  32'(mem_addr_o),  e_addr);
      checkOutput("mem_data",  32'(mem_data_o),  e_data);
      checkOutput("r_ready",   32'(r_ready_o),   e_rr);
      checkOutput("w_ready",   32'(w_ready_o),   e_wr);
      checkOutput("init_done", 32'(init_done_o), e_done);
      checkOutput("predict_v", 32'(predict_v_o), e_pv);
      checkOutput("predict",   32'(predict_o),   e_p);
   end

   initial begin
      reset_n_i = 1'b0;
      flush_i = 0; r_v_i = 0; r_idx_i = '0; w_v_i = 0; w_idx_i = '0; w_taken_i = 0;
      $display("[TB] start, flush feature = %0d", FLUSH_EN);
      idleCycles(3);

      // Reset release: eight sweep writes, init_done_o in cycle 9
      applyStimulus(0, 0, 0, 0, 0, 0);
      reset_n_i = 1'b1;
      for (int k = 1; k <= N; k++) begin
         if (k > 1) applyStimulus(0, 0, 0, 0, 0, 0);
         #1;
         checkOutput("sweep_done_low", 32'(init_done_o), 0);
         checkOutput("sweep_addr",     32'(mem_addr_o),  k - 1);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      #1 checkOutput("init_done_c9", 32'(init_done_o), 1);

      // Three taken updates to idx 5: 01 -> 10 -> 11 -> 11
      applyStimulus(0, 0, 1, 5, 1, 0);
      applyStimulus(0, 0, 1, 5, 1, 0);
      #1;
      checkOutput("rmw_rd_w",    32'(mem_w_o),    0);
      checkOutput("rmw_rd_addr", 32'(mem_addr_o), 5);
      applyStimulus(0, 0, 1, 5, 1, 0);
      #1;
      checkOutput("rmw_wr_w",    32'(mem_w_o),    1);
      checkOutput("rmw_wr_data", 32'(mem_data_o), 2);
      idleCycles(6);
      applyStimulus(1, 5, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("pred5_v",   32'(predict_v_o), 1);
      checkOutput("pred5",     32'(predict_o),   1);
      checkOutput("sram5_sat", 32'(sram[5]),     3);
      checkOutput("model5",    32'(ref_tbl[5]),  3);

      // Continuous reads while the FIFO fills: RD/WR steal the port
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, i, 1, 2, 1, 0);
      applyStimulus(1, 1, 1, 3, 0, 0);
      #1;
      checkOutput("full_w_ready", 32'(w_ready_o), 0);
      checkOutput("full_r_ready", 32'(r_ready_o), 0);
      checkOutput("full_rd_w",    32'(mem_w_o),   0);
      applyStimulus(1, 1, 0, 0, 0, 0);
      #1;
      checkOutput("full_wr_r_ready", 32'(r_ready_o), 0);
      checkOutput("full_wr_w",       32'(mem_w_o),   1);
      applyStimulus(1, 2, 0, 0, 0, 0);
      #1 checkOutput("resume_r_ready", 32'(r_ready_o), 1);
      applyStimulus(1, 2, 0, 0, 0, 0);
      idleCycles(8);

      // Not-taken at 00 must not underflow
      applyStimulus(0, 0, 1, 6, 0, 0);
      idleCycles(2);
      #1 checkOutput("dec_to_00", 32'(mem_data_o), 0);
      applyStimulus(0, 0, 1, 6, 0, 0);
      idleCycles(2);
      #1;
      checkOutput("no_underflow_addr", 32'(mem_addr_o), 6);
      checkOutput("no_underflow_data", 32'(mem_data_o), 0);
      applyStimulus(1, 6, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      #1 checkOutput("pred6", 32'(predict_o), 0);

      // Flush during a WR phase with two updates queued
      applyStimulus(0, 0, 1, 1, 1, 0);
      applyStimulus(0, 0, 1, 4, 1, 0);
      applyStimulus(0, 0, 1, 7, 0, 1);
      #1;
      checkOutput("flush_wr_w",    32'(mem_w_o),    1);
      checkOutput("flush_wr_addr", 32'(mem_addr_o), 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("flush_done", 32'(init_done_o), FLUSH_EN ? 0 : 1);
      checkOutput("flush_addr", 32'(mem_addr_o),  FLUSH_EN ? 0 : 4);
      idleCycles(2);
      applyStimulus(0, 0, 0, 0, 0, 1);
      idleCycles(12);
      applyStimulus(1, 1, 0, 0, 0, 0);
      idleCycles(2);

      // Asynchronous reset in the middle of an RMW
      applyStimulus(0, 0, 1, 3, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      #1 checkOutput("pre_reset_wr", 32'(mem_w_o), 1);
      #2 reset_n_i = 1'b0;
      #1;
      checkOutput("arst_mem_v",     32'(mem_v_o),     0);
      checkOutput("arst_mem_w",     32'(mem_w_o),     0);
      checkOutput("arst_mem_addr",  32'(mem_addr_o),  0);
      checkOutput("arst_mem_data",  32'(mem_data_o),  0);
      checkOutput("arst_w_ready",   32'(w_ready_o),   0);
      checkOutput("arst_init_done", 32'(init_done_o), 0);
      idleCycles(2);
      applyStimulus(0, 0, 0, 0, 0, 0);
      reset_n_i = 1'b1;
      idleCycles(N);
      applyStimulus(1, 3, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("pred3_after_reset_v", 32'(predict_v_o), 1);
      checkOutput("pred3_after_reset",   32'(predict_o),   0);
      idleCycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
